// File: rtl/dma_engine.sv
// dma_engine: cycle-stealing single-channel byte DMA sharing the CPU data bus (CPU always wins).
// Define DMA_FILL_EN to add fill mode (CTRL.FILL: SRC_LO is written repeatedly to DST).
module dma_engine #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_w_en,
    input  logic              cpu_r_en,
    output logic [ADDR_W-1:0] bus_address,
    output logic [7:0]        bus_dout,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [7:0]        bus_din,
    input  logic [2:0]        cfg_address,
    input  logic [7:0]        cfg_din,
    input  logic              cfg_w_en,
    input  logic              cfg_r_en,
    output logic [7:0]        cfg_dout,
    output logic              busy,
    output logic              done_flag,
    input  logic              done_flag_clr
);
    localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_CAPTURE = 2'd2, S_WRITE = 2'd3;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_src, r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [7:0]        r_data, r_cfg_dout, w_rdata, w_wdata;
    logic              r_ie, r_done, r_done_flag;
    logic              w_cpu, w_idle, w_grant_r, w_grant_w, w_ctrl_wr, w_start, w_abort;
    logic              w_last, w_complete, w_ie, w_fill, w_fill_q;
    assign w_cpu     = cpu_w_en | cpu_r_en;
    assign w_idle    = r_state == S_IDLE;
    // A reset cycle must not issue the access the current state would otherwise make.
    assign w_grant_r = !w_cpu && !rst && r_state == S_READ;
    assign w_grant_w = !w_cpu && !rst && r_state == S_WRITE;
    assign w_ctrl_wr = cfg_w_en && cfg_address == 3'd6;
    assign w_start   = w_ctrl_wr && cfg_din[0] && w_idle;
    assign w_abort   = w_ctrl_wr && cfg_din[2] && !w_idle;
    assign w_last    = r_len == LEN_W'(1);
    assign w_ie      = w_ctrl_wr ? cfg_din[1] : r_ie;
    assign w_complete = (w_start && r_len == '0) || (w_grant_w && w_last && !w_abort);
`ifdef DMA_FILL_EN
    logic r_fill;
    assign w_fill   = (w_ctrl_wr && w_idle) ? cfg_din[3] : r_fill;
    assign w_fill_q = r_fill;
`else
    assign w_fill   = 1'b0;
    assign w_fill_q = 1'b0;
`endif
    assign w_wdata     = w_fill ? r_src[7:0] : r_data;
    assign bus_address = w_cpu ? cpu_address : w_grant_r ? r_src : w_grant_w ? r_dst : cpu_address;
    assign bus_dout    = (!w_cpu && w_grant_w) ? w_wdata : cpu_din;
    assign bus_w_en    = w_cpu ? cpu_w_en : w_grant_w;
    assign bus_r_en    = w_cpu ? cpu_r_en : w_grant_r;
    assign busy        = !w_idle;
    assign done_flag   = r_done_flag;
    assign cfg_dout    = r_cfg_dout;
    always_comb begin
        w_rdata = 8'h00;
        case (cfg_address)
            3'd0: w_rdata = r_src[7:0];
            3'd1: w_rdata = 8'(r_src >> 8);
            3'd2: w_rdata = r_dst[7:0];
            3'd3: w_rdata = 8'(r_dst >> 8);
            3'd4: w_rdata = r_len[7:0];
            3'd5: w_rdata = 8'(r_len >> 8);
            3'd6: w_rdata = {4'b0, w_fill_q, 1'b0, r_ie, 1'b0};
            default: w_rdata = {6'b0, r_done, busy};
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_ie        <= 1'b0;
            r_done      <= 1'b0;
            r_done_flag <= 1'b0;
            r_cfg_dout  <= '0;
`ifdef DMA_FILL_EN
            r_fill      <= 1'b0;
`endif
        end else begin
            if (cfg_r_en) r_cfg_dout <= w_rdata;
            if (cfg_w_en && w_idle) begin
                case (cfg_address)
                    3'd0: r_src[7:0] <= cfg_din;
                    3'd1: r_src[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
                    3'd2: r_dst[7:0] <= cfg_din;
                    3'd3: r_dst[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
                    3'd4: r_len[7:0] <= cfg_din;
                    3'd5: r_len[LEN_W-1:8] <= cfg_din[LEN_W-9:0];
                    default: ;
                endcase
            end
            if (w_ctrl_wr) r_ie <= cfg_din[1];
`ifdef DMA_FILL_EN
            if (w_ctrl_wr && w_idle) r_fill <= cfg_din[3];
`endif
            if (w_complete) r_done <= 1'b1;
            else if (cfg_w_en && cfg_address == 3'd7 && cfg_din[1]) r_done <= 1'b0;
            if (w_complete && w_ie) r_done_flag <= 1'b1;
            else if (done_flag_clr) r_done_flag <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start && r_len != '0) r_state <= w_fill ? S_WRITE : S_READ;
                S_READ: r_state <= w_abort ? S_IDLE : w_grant_r ? S_CAPTURE : S_READ;
                S_CAPTURE: begin
                    r_data  <= bus_din;
                    r_state <= w_abort ? S_IDLE : S_WRITE;
                end
                default: begin
                    if (w_abort) r_state <= S_IDLE;
                    else if (w_grant_w) begin
                        r_src   <= w_fill ? r_src : r_src + ADDR_W'(1);
                        r_dst   <= r_dst + ADDR_W'(1);
                        r_len   <= r_len - LEN_W'(1);
                        r_state <= w_last ? S_IDLE : w_fill ? S_WRITE : S_READ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: register/bus-mux vector tables, directed corner sequences and randomized copies
// checked against a byte-array model of memory and the transfer arithmetic.
module tb_dma_engine;
    logic        clk = 0, rst = 1;
    logic [15:0] cpu_address = 0;
    logic [7:0]  cpu_din = 0;
    logic        cpu_w_en = 0, cpu_r_en = 0;
    logic [15:0] bus_address;
    logic [7:0]  bus_dout, cfg_dout;
    logic        bus_w_en, bus_r_en, busy, done_flag;
    logic [7:0]  bus_din = 0;
    logic [2:0]  cfg_address = 0;
    logic [7:0]  cfg_din = 0;
    logic        cfg_w_en = 0, cfg_r_en = 0, done_flag_clr = 0;
    int          n_run = 0, n_fail = 0, cyc = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] wq_a[$], rq_a[$];
    logic [7:0]  wq_d[$];
    int          wq_c[$];

    typedef struct {logic [2:0] a; logic [7:0] d; logic [7:0] e;} reg_t;
    typedef struct {logic [15:0] a; logic [7:0] d; logic w, r; logic [15:0] ea; logic ew, er;} mux_t;

    always #5 clk = ~clk;

    dma_engine dut (
        .clk(clk), .rst(rst), .cpu_address(cpu_address), .cpu_din(cpu_din),
        .cpu_w_en(cpu_w_en), .cpu_r_en(cpu_r_en), .bus_address(bus_address),
        .bus_dout(bus_dout), .bus_w_en(bus_w_en), .bus_r_en(bus_r_en), .bus_din(bus_din),
        .cfg_address(cfg_address), .cfg_din(cfg_din), .cfg_w_en(cfg_w_en),
        .cfg_r_en(cfg_r_en), .cfg_dout(cfg_dout), .busy(busy), .done_flag(done_flag),
        .done_flag_clr(done_flag_clr)
    );

    // Memory behind the decoder, plus a log of every engine-issued access.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_r_en) bus_din <= mem[bus_address];
        if (bus_w_en) mem[bus_address] <= bus_dout;
        if (!(cpu_w_en || cpu_r_en)) begin
            if (bus_w_en) begin
                wq_a.push_back(bus_address);
                wq_d.push_back(bus_dout);
                wq_c.push_back(cyc);
            end
            if (bus_r_en) rq_a.push_back(bus_address);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
        cfg_address = a; cfg_din = d; cfg_w_en = 1;
        tick;
        cfg_w_en = 0;
    endtask

    task automatic cfg_rd(input logic [2:0] a, output logic [7:0] v);
        cfg_address = a; cfg_r_en = 1;
        tick;
        cfg_r_en = 0;
        v = cfg_dout;
    endtask

    task automatic rd16(input logic [2:0] a, output int v);
        logic [7:0] lo, hi;
        cfg_rd(a, lo);
        cfg_rd(3'(a + 1), hi);
        v = {16'h0, hi, lo};
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        cfg_wr(0, s[7:0]); cfg_wr(1, s[15:8]);
        cfg_wr(2, d[7:0]); cfg_wr(3, d[15:8]);
        cfg_wr(4, l[7:0]); cfg_wr(5, l[15:8]);
    endtask

    task automatic clear_done;
        cfg_wr(7, 8'h02);
        done_flag_clr = 1;
        tick;
        done_flag_clr = 0;
    endtask

    // mode 0: CPU idle, 1: CPU reads every other cycle, 2: random CPU reads
    task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input int len,
                            input bit ie, input int mode);
        logic [7:0] exp[$];
        logic [7:0] v;
        int wsz, rsz, st, k, r;
        for (int i = 0; i < len; i++) exp.push_back(mem[16'(src + i)]);
        setup(src, dst, 16'(len));
        wsz = wq_a.size(); rsz = rq_a.size(); st = cyc;
        cfg_wr(6, ie ? 8'h03 : 8'h01);
        k = 0;
        while (busy && k < 40 * len + 20) begin
            cpu_address = 16'h0100;
            cpu_r_en = (mode == 1) ? (k % 2 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (cpu_r_en) begin
                chk("cpu_mirror_addr", bus_address, 16'h0100);
                chk("cpu_mirror_en", {bus_w_en, bus_r_en}, 2'b01);
            end
            tick;
            k++;
        end
        cpu_r_en = 0;
        chk("copy_timeout", busy, 0);
        chk("copy_nwrites", wq_a.size() - wsz, len);
        chk("copy_nreads", rq_a.size() - rsz, len);
        for (int i = 0; i < len && wsz + i < wq_a.size() && rsz + i < rq_a.size(); i++) begin
            chk($sformatf("copy_raddr[%0d]", i), rq_a[rsz + i], 16'(src + i));
            chk($sformatf("copy_waddr[%0d]", i), wq_a[wsz + i], 16'(dst + i));
            chk($sformatf("copy_wdata[%0d]", i), wq_d[wsz + i], exp[i]);
            chk($sformatf("copy_mem[%0d]", i), mem[16'(dst + i)], exp[i]);
            if (mode == 0) chk($sformatf("copy_wcycle[%0d]", i), wq_c[wsz + i] - st, 3 * (i + 1));
        end
        rd16(0, r); chk("copy_src_end", r, 32'(16'(src + len)));
        rd16(2, r); chk("copy_dst_end", r, 32'(16'(dst + len)));
        rd16(4, r); chk("copy_len_end", r, 0);
        cfg_rd(7, v); chk("copy_status", v, 8'h02);
        chk("copy_done_flag", done_flag, ie);
        clear_done;
    endtask

    initial begin
        reg_t reg_v[8];
        mux_t mux_v[4];
        logic [7:0] v;
        int r, wsz, rsz, st, k;
        reg_v[0] = '{3'd0, 8'h34, 8'h34};
        reg_v[1] = '{3'd1, 8'h12, 8'h12};
        reg_v[2] = '{3'd2, 8'h78, 8'h78};
        reg_v[3] = '{3'd3, 8'h56, 8'h56};
        reg_v[4] = '{3'd4, 8'h03, 8'h03};
        reg_v[5] = '{3'd5, 8'hA5, 8'hA5};
`ifdef DMA_FILL_EN
        reg_v[6] = '{3'd6, 8'h0A, 8'h0A};
`else
        reg_v[6] = '{3'd6, 8'h0A, 8'h02};
`endif
        reg_v[7] = '{3'd6, 8'h02, 8'h02};
        mux_v[0] = '{16'h1234, 8'h5A, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
        mux_v[1] = '{16'h0456, 8'h11, 1'b1, 1'b0, 16'h0456, 1'b1, 1'b0};
        mux_v[2] = '{16'h2001, 8'h22, 1'b0, 1'b1, 16'h2001, 1'b0, 1'b1};
        mux_v[3] = '{16'hFFFF, 8'h33, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done_flag", done_flag, 0);
        chk("rst_cfg_dout", cfg_dout, 0);
        chk("rst_bus_en", {bus_w_en, bus_r_en}, 0);
        chk("rst_bus_address", bus_address, 0);
        chk("rst_bus_dout", bus_dout, 0);
        rst = 0;
        tick;
        cfg_rd(7, v); chk("rst_status", v, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_wr(reg_v[i].a, reg_v[i].d);
            cfg_rd(reg_v[i].a, v);
            chk($sformatf("reg_rw[%0d]", i), v, reg_v[i].e);
        end

        for (int i = 0; i < 4; i++) begin
            cpu_address = mux_v[i].a; cpu_din = mux_v[i].d;
            cpu_w_en = mux_v[i].w; cpu_r_en = mux_v[i].r;
            #1;
            chk($sformatf("mux_addr[%0d]", i), bus_address, mux_v[i].ea);
            chk($sformatf("mux_en[%0d]", i), {bus_w_en, bus_r_en}, {mux_v[i].ew, mux_v[i].er});
            if (mux_v[i].w) chk($sformatf("mux_dout[%0d]", i), bus_dout, mux_v[i].d);
            tick;
        end
        cpu_address = 0; cpu_din = 0; cpu_w_en = 0; cpu_r_en = 0;

        run_copy(16'h0010, 16'h2000, 4, 1, 0);
        run_copy(16'h0010, 16'h2000, 4, 1, 1);
        run_copy(16'hFFFF, 16'h2100, 2, 0, 0);

        setup(16'h0300, 16'h2300, 16'h0000);
        wsz = wq_a.size(); rsz = rq_a.size();
        cfg_wr(6, 8'h03);
        tick;
        chk("len0_no_access", (wq_a.size() - wsz) + (rq_a.size() - rsz), 0);
        chk("len0_busy", busy, 0);
        cfg_rd(7, v); chk("len0_status", v, 8'h02);
        chk("len0_done_flag", done_flag, 1);
        clear_done;
        chk("flag_clr_alone", done_flag, 0);
        cfg_rd(7, v); chk("status_clear", v, 0);
        cfg_address = 6; cfg_din = 8'h03; cfg_w_en = 1; done_flag_clr = 1;
        tick;
        cfg_w_en = 0; done_flag_clr = 0;
        chk("flag_set_wins", done_flag, 1);
        done_flag_clr = 1;
        tick;
        done_flag_clr = 0;
        chk("flag_clr_after", done_flag, 0);
        cfg_wr(7, 8'h02);

        setup(16'h0040, 16'h2200, 16'd5);
        wsz = wq_a.size(); rsz = rq_a.size();
        cfg_wr(6, 8'h03);
        tick;
        cfg_wr(4, 8'h55);
        tick;
        cfg_wr(6, 8'h03);
        chk("abort_busy_before", busy, 1);
        cfg_wr(6, 8'h06);
        chk("abort_busy", busy, 0);
        chk("abort_nwrites", wq_a.size() - wsz, 1);
        chk("abort_nreads", rq_a.size() - rsz, 2);
        rd16(4, r); chk("abort_len", r, 4);
        rd16(0, r); chk("abort_src", r, 16'h0041);
        rd16(2, r); chk("abort_dst", r, 16'h2201);
        chk("abort_done_flag", done_flag, 0);
        cfg_rd(7, v); chk("abort_status", v, 0);

        setup(16'h0050, 16'h2400, 16'd3);
        wsz = wq_a.size();
        cfg_wr(6, 8'h01);
        tick; tick;
        rst = 1;
        #1;
        chk("rst_mid_no_write", bus_w_en, 0);
        tick;
        rst = 0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_nwrites", wq_a.size() - wsz, 0);
        rd16(4, r); chk("rst_mid_len", r, 0);

`ifdef DMA_FILL_EN
        setup(16'h00AA, 16'h2000, 16'd3);
        wsz = wq_a.size(); rsz = rq_a.size(); st = cyc;
        cfg_wr(6, 8'h09);
        k = 0;
        while (busy && k < 50) begin tick; k++; end
        chk("fill_timeout", busy, 0);
        chk("fill_nwrites", wq_a.size() - wsz, 3);
        chk("fill_nreads", rq_a.size() - rsz, 0);
        for (int i = 0; i < 3 && wsz + i < wq_a.size(); i++) begin
            chk($sformatf("fill_waddr[%0d]", i), wq_a[wsz + i], 16'h2000 + i);
            chk($sformatf("fill_wdata[%0d]", i), wq_d[wsz + i], 8'hAA);
            chk($sformatf("fill_wcycle[%0d]", i), wq_c[wsz + i] - st, i + 1);
        end
        rd16(0, r); chk("fill_src", r, 16'h00AA);
        rd16(2, r); chk("fill_dst", r, 16'h2003);
        cfg_wr(6, 8'h00);
        clear_done;
`endif

        for (int t = 0; t < 10; t++)
            run_copy(16'($urandom_range(0, 16'h07F0)), 16'($urandom_range(16'h2000, 16'h28F0)),
                     $urandom_range(1, 8), 1'($urandom_range(0, 1)), 2 * $urandom_range(0, 1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
- Single-channel, cycle-stealing DMA controller that shares the 16-bit CPU data/IO bus (D_MEM 0x0000-0x07FF, I/O 0x1000-0x10FF, V_MEM 0x2000-0x2960) between the CPU and a byte-copy engine.
- Sits between the CPU data port and the memory-map decoder. The CPU always wins. The engine issues accesses only in cycles where the CPU has neither read nor write enable asserted.
- The CPU configures it through an 8-byte register window in I/O space. It raises an interrupt flag on completion, using the same flag/clr convention as the other interrupt sources.

Parameters:
- ADDR_W, 16, bus address width
- LEN_W, 16, transfer length counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_address  in  16  CPU data address
- cpu_din  in  8  CPU write data
- cpu_w_en  in  1  CPU write enable
- cpu_r_en  in  1  CPU read enable
- bus_address  out  16  address to memory-map decoder
- bus_dout  out  8  write data to decoder
- bus_w_en  out  1  write enable to decoder
- bus_r_en  out  1  read enable to decoder
- bus_din  in  8  decoder read data; valid the cycle after r_en, for the access issued that cycle
- cfg_address  in  3  register select (I/O offset)
- cfg_din  in  8  register write data
- cfg_w_en  in  1  register write strobe
- cfg_r_en  in  1  register read strobe
- cfg_dout  out  8  register read data, registered
- busy  out  1  transfer in progress
- done_flag  out  1  completion interrupt flag
- done_flag_clr  in  1  interrupt acknowledge pulse

Behaviour:
- Reset:
  - All outputs are 0.
  - SRC, DST, LEN and CTRL are 0; state is IDLE; done_flag is 0.
- Bus mux (combinational):
  - If cpu_w_en|cpu_r_en, the bus mirrors the CPU: bus_address=cpu_address, bus_dout=cpu_din, bus_w_en/bus_r_en = CPU enables.
  - Otherwise the engine drives the bus.
  - When idle and the CPU is idle: bus_address=cpu_address, and both enables are 0.
- Registers, at cfg_address:
  - 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI.
  - 6 CTRL: bit0 START (self-clearing), bit1 IE, bit2 ABORT (self-clearing), bit3 FILL.
  - 7 STATUS: bit0 busy, bit1 done; read-only. Writing 1 to bit1 clears it.
  - cfg_dout is updated 1 cycle after cfg_r_en and holds otherwise.
  - SRC/DST/LEN reads return the live counters.
  - Writes to regs 0-5 while busy are ignored.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - START with LEN=0 sets done (and done_flag if IE) with no bus access.
  - START with LEN≠0 goes to READ and sets busy=1.
- READ:
  - In a cycle with a free bus: bus_r_en=1 with bus_address=SRC, then go to CAPTURE.
  - Otherwise stay in READ.
- CAPTURE: latch bus_din into the data register (uses no bus), then go to WRITE.
- WRITE:
  - In a cycle with a free bus: bus_w_en=1, bus_address=DST, bus_dout=data.
  - Then SRC+=1, DST+=1, LEN-=1 (all mod 2^16; 0xFFFF wraps to 0x0000).
  - If the old LEN is 1: go to IDLE, busy=0, set STATUS.done, and set done_flag if IE.
  - Otherwise go to READ.
- Throughput: a minimum of 3 cycles per byte with the bus uncontested. CPU contention stretches READ/WRITE only.
- START while busy is ignored.
- ABORT in any non-IDLE state:
  - Return to IDLE next cycle; no done.
  - Counters hold their current values.
  - A bus access in the abort cycle is still issued if the bus was already granted.
- done_flag:
  - Set and done_flag_clr in the same cycle: set wins.
  - The flag stays high until cleared.
- rst mid-transfer: immediate return to reset state; a pending write is not issued.
- Overlapping CPU/DMA accesses to the same address: the CPU access occurs first within any cycle. No coherence is provided.

Optional Feature:
- Macro: DMA_FILL_EN.
- Defined:
  - CTRL.FILL=1 selects fill mode. The FSM skips READ/CAPTURE, and each WRITE stores SRC_LO (constant) to DST.
  - SRC is not incremented in fill mode.
  - Minimum 1 cycle per byte.
- Undefined: CTRL bit3 is not stored, reads as 0, and every transfer is a copy.

Test Plan:
- Copy 4 bytes 0x0010→0x2000 (D_MEM→V_MEM), CPU idle, IE=1 → writes at 0x2000-0x2003 on cycles 3,6,9,12 after START. Then busy=0, done_flag=1, SRC=0x0014, DST=0x2004, LEN=0.
- Same copy with cpu_r_en asserted every other cycle → CPU sees bus_address=cpu_address in those cycles, and no DMA enable is asserted in them. Data copied is identical; completion is delayed.
- START with LEN=0 → no bus_r_en/bus_w_en pulses. STATUS reads 0x02 one cycle after cfg_r_en; done_flag=1 if IE.
- Wrap: SRC=0xFFFF, LEN=2 → reads at 0xFFFF then 0x0000.
- ABORT after the first byte of LEN=5 → LEN reads 4, busy=0, done_flag stays 0. A second START while busy is ignored.
- done_flag set and done_flag_clr coincide → done_flag=1. A clr pulse alone → 0.
- DMA_FILL_EN with FILL=1, SRC_LO=0xAA, DST=0x2000, LEN=3 → three bus_w_en pulses with bus_dout=0xAA on consecutive free cycles, and no bus_r_en pulses.
